// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the responder end of the CPU memory bus:
//   - BUS_W / WORD_BYTES geometry of the 64-bit word bus
//   - ram_state_e : responder FSM states (wait states only reachable when the
//                   RAM_WAIT_EN macro is defined in bus_ram)
//   - decode_addr : byte address -> word index plus an "access ok" flag
// -----------------------------------------------------------------------------
package cpu_bus_pkg;

  localparam int unsigned BUS_W      = 64;
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_DATA = 3'd1,
    WR_DONE = 3'd2,
    RD_WAIT = 3'd3,
    WR_WAIT = 3'd4
  } ram_state_e;

  typedef struct packed {
    logic [BUS_W-1:0] idx;  // word index relative to the base address
    logic             ok;   // aligned and inside [base, base + depth words)
  } decode_t;

  function automatic decode_t decode_addr(input logic [BUS_W-1:0] addr,
                                          input logic [BUS_W-1:0] base,
                                          input logic [BUS_W-1:0] depth);
    decode_t d;
    d.idx = (addr - base) >> WORD_SHIFT;
    d.ok  = (addr[WORD_SHIFT-1:0] == '0) && (addr >= base) && (d.idx < depth);
    return d;
  endfunction

endpackage

// File: rtl/bus_ram_array.sv
// -----------------------------------------------------------------------------
// bus_ram_array
// DEPTH x 64-bit word storage, synchronous write, asynchronous read.
// Ports:
//   clk       in   clock for the write port
//   we_i      in   write enable (one word per cycle)
//   addr_i    in   word index shared by read and write
//   wdata_i   in   write data
//   rdata_o   out  combinational read of mem[addr_i]
// -----------------------------------------------------------------------------
module bus_ram_array
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [BUS_W-1:0] wdata_i,
  output logic [BUS_W-1:0] rdata_o
);

  logic [BUS_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; contents survive rst and a reset branch would
  // stop the array mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_ram.sv
// -----------------------------------------------------------------------------
// bus_ram
// Responder end of the CPU memory bus: 64-bit word RAM with registered read
// data, one commit per write strobe, registered ready and a sticky decode error.
// Ports:
//   clk        in    clock, all state on the rising edge
//   reset      in    asynchronous active-low reset
//   bus_addr   in    byte address from the initiator
//   bus_data   inout driven only in RD_DATA while cs&oe&!we, otherwise Z
//   ram_cs     in    chip select
//   ram_we     in    write strobe (wins over ram_oe)
//   ram_oe     in    read strobe
//   ram_ready  out   read data valid / write committed
//   ram_err    out   sticky misaligned / out-of-range flag, cleared by reset
// Configuration macro RAM_WAIT_EN: adds WAIT_CYCLES wait states per access
// (RD_WAIT/WR_WAIT); without it every access completes in one clock.
// -----------------------------------------------------------------------------
module bus_ram
  import cpu_bus_pkg::*;
#(
  parameter int unsigned      DEPTH       = 1024,
  parameter logic [BUS_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned      WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BUS_W-1:0] bus_addr,
  inout  wire  [BUS_W-1:0] bus_data,
  input  logic             ram_cs,
  input  logic             ram_we,
  input  logic             ram_oe,
  output logic             ram_ready,
  output logic             ram_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ram_state_e       state_q;
  logic [BUS_W-1:0] rdata_q;
  logic [BUS_W-1:0] addr_q;
  logic             ready_q;
  logic             err_q;

  logic             strobe_wr;
  logic             strobe_rd;
  logic             addr_moved;
  logic [BUS_W-1:0] acc_addr;
  decode_t          dec;
  logic             mem_we;
  logic [BUS_W-1:0] mem_rdata;
  logic             drive_en;
  logic             unused_idx_hi;

  assign strobe_wr  = ram_cs & ram_we;
  assign strobe_rd  = ram_cs & ram_oe & ~ram_we;
  assign addr_moved = (bus_addr != addr_q);

`ifdef RAM_WAIT_EN
  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wait_done;

  assign cnt_d     = cnt_q - CW'(1);
  assign wait_done = (cnt_d == '0);
  // While waiting, the access completes at the address captured at the strobe.
  assign acc_addr  = (state_q == RD_WAIT || state_q == WR_WAIT) ? addr_q : bus_addr;
`else
  localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
  assign acc_addr = bus_addr;
`endif

  assign dec           = decode_addr(acc_addr, BASE_ADDR, BUS_W'(DEPTH));
  assign unused_idx_hi = ^dec.idx[BUS_W-1:AW];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mem_we = 1'b0;
`ifdef RAM_WAIT_EN
    if (state_q == WR_WAIT && strobe_wr && wait_done) mem_we = dec.ok;
`else
    if (strobe_wr && (state_q == IDLE || (state_q == WR_DONE && addr_moved)))
      mem_we = dec.ok;
`endif
  end

  bus_ram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (dec.idx[AW-1:0]),
    .wdata_i (bus_data),
    .rdata_o (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef RAM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (strobe_wr) begin
            addr_q  <= bus_addr;
`ifdef RAM_WAIT_EN
            cnt_q   <= CW'(WAIT_CYCLES);
            state_q <= WR_WAIT;
`else
            err_q   <= err_q | ~dec.ok;
            ready_q <= 1'b1;
            state_q <= WR_DONE;
`endif
          end else if (strobe_rd) begin
            addr_q  <= bus_addr;
`ifdef RAM_WAIT_EN
            cnt_q   <= CW'(WAIT_CYCLES);
            state_q <= RD_WAIT;
`else
            rdata_q <= dec.ok ? mem_rdata : '0;
            err_q   <= err_q | ~dec.ok;
            ready_q <= 1'b1;
            state_q <= RD_DATA;
`endif
          end
        end

`ifdef RAM_WAIT_EN
        RD_WAIT: begin
          if (!strobe_rd) begin
            state_q <= IDLE;
          end else if (wait_done) begin
            rdata_q <= dec.ok ? mem_rdata : '0;
            err_q   <= err_q | ~dec.ok;
            ready_q <= 1'b1;
            state_q <= RD_DATA;
          end else begin
            cnt_q   <= cnt_d;
          end
        end

        WR_WAIT: begin
          if (!strobe_wr) begin
            state_q <= IDLE;
          end else if (wait_done) begin
            err_q   <= err_q | ~dec.ok;
            ready_q <= 1'b1;
            state_q <= WR_DONE;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
`endif

        // Strobe drop, a new write or an address change all leave through
        // IDLE, which drops ready for one cycle before the next access.
        RD_DATA: begin
          if (!strobe_rd || addr_moved) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end

        // A held write strobe commits once; only a new address commits again.
        WR_DONE: begin
          if (!strobe_wr) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end else if (addr_moved) begin
            addr_q  <= bus_addr;
`ifdef RAM_WAIT_EN
            cnt_q   <= CW'(WAIT_CYCLES);
            ready_q <= 1'b0;
            state_q <= WR_WAIT;
`else
            err_q   <= err_q | ~dec.ok;
`endif
          end
        end

        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive enable is combinational so the bus floats in the same cycle the
  // strobe drops; reset forces IDLE asynchronously, releasing it at once.
  assign drive_en  = (state_q == RD_DATA) && strobe_rd;
  assign bus_data  = drive_en ? rdata_q : 'z;
  assign ram_ready = ready_q;
  assign ram_err   = err_q;

endmodule
